// File: rtl/cpc_bus_cycle_tracker_if.sv
// cpc_bus_cycle_tracker_if: CPC expansion-bus strobes into the tracker and its cycle/bank outputs.
interface cpc_bus_cycle_tracker_if;
    logic       mreq_b, iorq_b, rd_b, wr_b, rfsh_b, m1_b, ready, adr15;
    logic [7:0] data;
    logic [2:0] cyc_state;
    logic       mrd_cyc, mwr_cyc, ramblock_vld;
    logic [5:0] ramblock;
    logic [3:0] wait_cnt;
    modport master (
        output mreq_b, iorq_b, rd_b, wr_b, rfsh_b, m1_b, ready, adr15, data,
        input  cyc_state, mrd_cyc, mwr_cyc, ramblock, ramblock_vld, wait_cnt
    );
    modport slave (
        input  mreq_b, iorq_b, rd_b, wr_b, rfsh_b, m1_b, ready, adr15, data,
        output cyc_state, mrd_cyc, mwr_cyc, ramblock, ramblock_vld, wait_cnt
    );
endinterface

// File: rtl/cpc_bus_cycle_tracker.sv
// cpc_bus_cycle_tracker: Z80 machine-cycle classifier with RAM bank-select capture.
// Optional wait-state counter enabled by CPC_WAIT_CNT_EN.
module cpc_bus_cycle_tracker (
    input logic clk,
    input logic reset,
    cpc_bus_cycle_tracker_if.slave bus
);
    typedef enum logic [2:0] {IDLE, MRD, MWR, RFSH, IORD, IOWR, INTA, END} state_t;
    state_t     state, idle_nxt, nxt;
    logic       mreq_s, iorq_s, rd_s, wr_s, rfsh_s, m1_s, adr15_s;
    logic [7:0] data_s;
    logic       mreq_q, armed, captured;
    logic       mreq_fall, iorq_low, cap;
    assign mreq_fall = armed & mreq_q & ~mreq_s;
    assign iorq_low  = armed & ~iorq_s;
    assign cap       = state == IOWR && !adr15_s && data_s[7:6] == 2'b11 && !captured;
    assign idle_nxt  = mreq_fall ? (!rfsh_s ? RFSH : !rd_s ? MRD : MWR) :
                       iorq_low  ? (!m1_s ? INTA : !wr_s ? IOWR : !rd_s ? IORD : IDLE) : IDLE;
    assign nxt       = state == IDLE ? idle_nxt : state == END ? IDLE :
                       (mreq_s & iorq_s) ? END : state;
    assign bus.cyc_state = state;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {mreq_s, iorq_s, rd_s, wr_s, rfsh_s, m1_s} <= '1;
            adr15_s          <= 1'b0;
            data_s           <= '0;
            mreq_q           <= 1'b1;
            armed            <= 1'b0;
            captured         <= 1'b0;
            state            <= IDLE;
            bus.mrd_cyc      <= 1'b0;
            bus.mwr_cyc      <= 1'b0;
            bus.ramblock     <= '0;
            bus.ramblock_vld <= 1'b0;
        end else begin
            {mreq_s, iorq_s, rd_s, wr_s, rfsh_s, m1_s} <=
                {bus.mreq_b, bus.iorq_b, bus.rd_b, bus.wr_b, bus.rfsh_b, bus.m1_b};
            adr15_s          <= bus.adr15;
            data_s           <= bus.data;
            mreq_q           <= mreq_s;
            // arm on the raw strobes so reset-value S1 highs cannot fake an idle bus
            armed            <= armed | (bus.mreq_b & bus.iorq_b);
            captured         <= state == IOWR && (captured || cap);
            state            <= nxt;
            bus.mrd_cyc      <= nxt == MRD;
            bus.mwr_cyc      <= nxt == MWR;
            bus.ramblock_vld <= cap;
            if (cap) bus.ramblock <= data_s[5:0];
        end
    end
`ifdef CPC_WAIT_CNT_EN
    logic       ready_s;
    logic [3:0] wcnt;
    assign bus.wait_cnt = wcnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_s <= 1'b1;
            wcnt    <= '0;
        end else begin
            ready_s <= bus.ready;
            if (state == IDLE && nxt != IDLE) wcnt <= '0;
            else if (state != IDLE && state != END && !ready_s && wcnt != 4'hf) wcnt <= wcnt + 4'd1;
        end
    end
`else
    assign bus.wait_cnt = 4'd0;
`endif
endmodule

// File: tb/tb_cpc_bus_cycle_tracker.sv
// tb_cpc_bus_cycle_tracker: scoreboard bench; expected outputs queued per driven clock.
module tb_cpc_bus_cycle_tracker;
    // strobe byte: {mreq_b, iorq_b, rd_b, wr_b, rfsh_b, m1_b, ready, adr15}
    localparam logic [7:0] BI  = 8'b1111_1111, MRDB = 8'b0101_1111, MW0 = 8'b0111_1111,
                           MWB = 8'b0110_1111, RFS = 8'b0111_0111, BOTH = 8'b0001_1111,
                           IOW = 8'b1010_1110, IOR = 8'b1001_1110, INA = 8'b1011_1011,
                           MRW = 8'b0101_1101;
`ifdef CPC_WAIT_CNT_EN
    localparam bit WEN = 1'b1;
`else
    localparam bit WEN = 1'b0;
`endif
    typedef struct {
        logic [2:0] st;
        logic [5:0] rb;
        logic       vld;
        logic [3:0] wc;
    } exp_t;
    logic clk = 1'b0, reset = 1'b0;
    int   total = 0, bad = 0;
    exp_t q[$];
    exp_t e;
    cpc_bus_cycle_tracker_if b ();
    cpc_bus_cycle_tracker dut (.clk(clk), .reset(reset), .bus(b));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask
    task automatic drv(input logic rs, input logic [7:0] s, input logic [7:0] d,
                       input logic [2:0] es, input logic [5:0] erb, input logic ev,
                       input logic [3:0] ewc);
        @(negedge clk);
        reset = rs;
        {b.mreq_b, b.iorq_b, b.rd_b, b.wr_b, b.rfsh_b, b.m1_b, b.ready, b.adr15} = s;
        b.data = d;
        q.push_back('{es, erb, ev, ewc});
    endtask
    task automatic idle(input logic [2:0] es, input logic [5:0] erb, input logic [3:0] ewc);
        drv(1'b0, BI, 8'h00, es, erb, 1'b0, ewc);
    endtask
    always @(posedge clk) begin
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("cyc_state", 32'(b.cyc_state), 32'(e.st));
            chk("mrd_cyc", 32'(b.mrd_cyc), 32'(e.st == 3'd1));
            chk("mwr_cyc", 32'(b.mwr_cyc), 32'(e.st == 3'd2));
            chk("ramblock", 32'(b.ramblock), 32'(e.rb));
            chk("ramblock_vld", 32'(b.ramblock_vld), 32'(e.vld));
            chk("wait_cnt", 32'(b.wait_cnt), 32'(e.wc));
        end
    end
    initial begin
        {b.mreq_b, b.iorq_b, b.rd_b, b.wr_b, b.rfsh_b, b.m1_b, b.ready, b.adr15} = BI;
        b.data = 8'h00;
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_state", 32'(b.cyc_state), 32'd0);
        chk("rst_ramblock", 32'(b.ramblock), 32'd0);
        chk("rst_vld", 32'(b.ramblock_vld), 32'd0);
        chk("rst_wait", 32'(b.wait_cnt), 32'd0);
        drv(1'b1, BI, 8'h00, 3'd0, 6'h00, 1'b0, 4'd0);
        // MWR started, then reset mid-cycle with mreq held low
        idle(3'd0, 6'h00, 4'd0);
        drv(1'b0, MW0, 8'h00, 3'd0, 6'h00, 1'b0, 4'd0);
        drv(1'b0, MWB, 8'h00, 3'd2, 6'h00, 1'b0, 4'd0);
        drv(1'b0, MWB, 8'h00, 3'd2, 6'h00, 1'b0, 4'd0);
        drv(1'b1, MWB, 8'h00, 3'd0, 6'h00, 1'b0, 4'd0);
        drv(1'b0, MWB, 8'h00, 3'd0, 6'h00, 1'b0, 4'd0);
        drv(1'b0, MW0, 8'h00, 3'd0, 6'h00, 1'b0, 4'd0);
        drv(1'b0, MW0, 8'h00, 3'd0, 6'h00, 1'b0, 4'd0);
        idle(3'd0, 6'h00, 4'd0);
        // memory read after re-arm
        drv(1'b0, MRDB, 8'h00, 3'd0, 6'h00, 1'b0, 4'd0);
        drv(1'b0, MRDB, 8'h00, 3'd1, 6'h00, 1'b0, 4'd0);
        drv(1'b0, MRDB, 8'h00, 3'd1, 6'h00, 1'b0, 4'd0);
        idle(3'd1, 6'h00, 4'd0);
        idle(3'd7, 6'h00, 4'd0);
        idle(3'd0, 6'h00, 4'd0);
        // bank-select I/O write 0xD3
        drv(1'b0, IOW, 8'hD3, 3'd0, 6'h00, 1'b0, 4'd0);
        drv(1'b0, IOW, 8'hD3, 3'd5, 6'h00, 1'b0, 4'd0);
        drv(1'b0, IOW, 8'hD3, 3'd5, 6'h13, 1'b1, 4'd0);
        idle(3'd5, 6'h13, 4'd0);
        idle(3'd7, 6'h13, 4'd0);
        idle(3'd0, 6'h13, 4'd0);
        // non-matching I/O write 0x53
        drv(1'b0, IOW, 8'h53, 3'd0, 6'h13, 1'b0, 4'd0);
        drv(1'b0, IOW, 8'h53, 3'd5, 6'h13, 1'b0, 4'd0);
        drv(1'b0, IOW, 8'h53, 3'd5, 6'h13, 1'b0, 4'd0);
        idle(3'd5, 6'h13, 4'd0);
        idle(3'd7, 6'h13, 4'd0);
        idle(3'd0, 6'h13, 4'd0);
        // memory write, wr lags mreq
        drv(1'b0, MW0, 8'hD3, 3'd0, 6'h13, 1'b0, 4'd0);
        drv(1'b0, MWB, 8'hD3, 3'd2, 6'h13, 1'b0, 4'd0);
        drv(1'b0, MWB, 8'hD3, 3'd2, 6'h13, 1'b0, 4'd0);
        idle(3'd2, 6'h13, 4'd0);
        idle(3'd7, 6'h13, 4'd0);
        idle(3'd0, 6'h13, 4'd0);
        // refresh
        drv(1'b0, RFS, 8'h00, 3'd0, 6'h13, 1'b0, 4'd0);
        drv(1'b0, RFS, 8'h00, 3'd3, 6'h13, 1'b0, 4'd0);
        idle(3'd3, 6'h13, 4'd0);
        idle(3'd7, 6'h13, 4'd0);
        idle(3'd0, 6'h13, 4'd0);
        // simultaneous mreq/iorq: mreq wins
        drv(1'b0, BOTH, 8'h00, 3'd0, 6'h13, 1'b0, 4'd0);
        drv(1'b0, BOTH, 8'h00, 3'd1, 6'h13, 1'b0, 4'd0);
        idle(3'd1, 6'h13, 4'd0);
        idle(3'd7, 6'h13, 4'd0);
        idle(3'd0, 6'h13, 4'd0);
        // interrupt acknowledge
        drv(1'b0, INA, 8'h00, 3'd0, 6'h13, 1'b0, 4'd0);
        drv(1'b0, INA, 8'h00, 3'd6, 6'h13, 1'b0, 4'd0);
        idle(3'd6, 6'h13, 4'd0);
        idle(3'd7, 6'h13, 4'd0);
        idle(3'd0, 6'h13, 4'd0);
        // I/O read with bank-like data must not capture
        drv(1'b0, IOR, 8'hFF, 3'd0, 6'h13, 1'b0, 4'd0);
        drv(1'b0, IOR, 8'hFF, 3'd4, 6'h13, 1'b0, 4'd0);
        drv(1'b0, IOR, 8'hFF, 3'd4, 6'h13, 1'b0, 4'd0);
        idle(3'd4, 6'h13, 4'd0);
        idle(3'd7, 6'h13, 4'd0);
        idle(3'd0, 6'h13, 4'd0);
        // three sampled wait states in a memory read
        drv(1'b0, MRDB, 8'h00, 3'd0, 6'h13, 1'b0, 4'd0);
        drv(1'b0, MRW, 8'h00, 3'd1, 6'h13, 1'b0, 4'd0);
        drv(1'b0, MRW, 8'h00, 3'd1, 6'h13, 1'b0, WEN ? 4'd1 : 4'd0);
        drv(1'b0, MRW, 8'h00, 3'd1, 6'h13, 1'b0, WEN ? 4'd2 : 4'd0);
        drv(1'b0, MRDB, 8'h00, 3'd1, 6'h13, 1'b0, WEN ? 4'd3 : 4'd0);
        idle(3'd1, 6'h13, WEN ? 4'd3 : 4'd0);
        idle(3'd7, 6'h13, WEN ? 4'd3 : 4'd0);
        idle(3'd0, 6'h13, WEN ? 4'd3 : 4'd0);
        // twenty wait states saturate at 15
        drv(1'b0, MRDB, 8'h00, 3'd0, 6'h13, 1'b0, WEN ? 4'd3 : 4'd0);
        for (int i = 0; i < 20; i++)
            drv(1'b0, MRW, 8'h00, 3'd1, 6'h13, 1'b0, WEN ? 4'(i > 15 ? 15 : i) : 4'd0);
        idle(3'd1, 6'h13, WEN ? 4'd15 : 4'd0);
        idle(3'd7, 6'h13, WEN ? 4'd15 : 4'd0);
        idle(3'd0, 6'h13, WEN ? 4'd15 : 4'd0);
        repeat (4) @(negedge clk);
        if (q.size() != 0) chk("drain", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
